// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: valid/ready command front end for the 8-bit ALU with a shadow accumulator
module alu_cmd_sequencer #(
  parameter int WIDTH = 8,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             on,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic             cmd_acc,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic [2:0]       alu_in_sel,
  output logic [WIDTH-1:0] alu_num1,
  output logic [WIDTH-1:0] alu_num2,
  output logic [6:0]       alu_out_sel,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_overflow,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic             busy
);
  typedef enum logic [2:0] {OFF, IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state;
  logic [2:0] op;
  logic [WIDTH-1:0] acc;
  logic [3:0] cnt;
  logic [6:0] sel;
  logic ovf;
  assign cmd_ready = state == IDLE && on;
  assign busy = state != IDLE && state != OFF;
  assign sel = cmd_op == 3'd7 ? 7'b0000100 : 7'b1000000 >> cmd_op;
  assign ovf = alu_overflow && op == 3'd6;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      op <= '0;
      acc <= '0;
      cnt <= '0;
      rsp_valid <= 1'b0;
      rsp_data <= '0;
      rsp_err <= 1'b0;
      alu_in_sel <= 3'b001;
      alu_num1 <= '0;
      alu_num2 <= '0;
      alu_out_sel <= 7'b0000100;
    end else begin
      case (state)
        OFF: if (on) state <= IDLE;
        IDLE: begin
          if (!on) state <= OFF;
          else if (cmd_valid) begin
            state <= ISSUE;
            op <= cmd_op;
            alu_in_sel <= cmd_op == 3'd7 ? 3'b001 : 3'b010;
            alu_num1 <= cmd_acc ? acc : cmd_a;
            alu_num2 <= cmd_b;
            alu_out_sel <= sel;
          end
        end
        ISSUE: begin
          state <= WAIT;
          cnt <= 4'd1;
        end
        WAIT: begin
          if (cnt >= 4'(ALU_LAT)) begin
            state <= RESP;
            rsp_valid <= 1'b1;
            rsp_data <= op == 3'd7 ? '0 : alu_result;
            rsp_err <= ovf;
            acc <= op == 3'd7 ? '0 : ovf ? acc : alu_result;
          end else cnt <= cnt + 4'd1;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state <= on ? IDLE : OFF;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: randomized and directed checks of the ALU command sequencer against an op-level model
module tb_alu_cmd_sequencer;
  logic clk = 0, rst = 1, on = 1;
  always #5 clk = ~clk;

  logic cmd_valid = 0, cmd_acc = 0, rsp_ready = 0;
  logic [2:0] cmd_op = 0;
  logic [7:0] cmd_a = 0, cmd_b = 0;
  logic cmd_ready, alu_overflow, rsp_valid, rsp_err, busy;
  logic [2:0] alu_in_sel;
  logic [6:0] alu_out_sel;
  logic [7:0] alu_num1, alu_num2, alu_result, rsp_data;

  logic cmd_valid3 = 0, cmd_acc3 = 0, rsp_ready3 = 0;
  logic [2:0] cmd_op3 = 0;
  logic [7:0] cmd_a3 = 0, cmd_b3 = 0;
  logic cmd_ready3, alu_overflow3, rsp_valid3, rsp_err3, busy3;
  logic [2:0] alu_in_sel3;
  logic [6:0] alu_out_sel3;
  logic [7:0] alu_num1_3, alu_num2_3, alu_result3, rsp_data3;

  int n_checks = 0, n_fail = 0;
  logic [7:0] exp_acc = 0;
  logic [6:0] sel_tab [8] = '{7'h40, 7'h20, 7'h10, 7'h08, 7'h04, 7'h02, 7'h01, 7'h04};

  function automatic logic [8:0] alu_model(input logic [2:0] in_sel, input logic [6:0] sel, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = a * b;
    if (in_sel == 3'b001) return 9'h0;
    case (sel)
      7'b1000000: return {1'b0, a & b};
      7'b0100000: return {1'b0, a | b};
      7'b0010000: return {1'b0, ~a};
      7'b0001000: return {1'b0, a ^ b};
      7'b0000100: return {1'b0, 8'(a + b)};
      7'b0000010: return {1'b0, 8'(a - b)};
      7'b0000001: return {|p[15:8], p[7:0]};
      default: return 9'h0;
    endcase
  endfunction

  function automatic logic [8:0] ref_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int p;
    case (op)
      3'd0: return {1'b0, a & b};
      3'd1: return {1'b0, a | b};
      3'd2: return {1'b0, 8'(255 - int'(a))};
      3'd3: return {1'b0, a ^ b};
      3'd4: return {1'b0, 8'((int'(a) + int'(b)) % 256)};
      3'd5: return {1'b0, 8'((int'(a) - int'(b) + 256) % 256)};
      3'd6: begin
        p = int'(a) * int'(b);
        return {p > 255, 8'(p % 256)};
      end
      default: return 9'h0;
    endcase
  endfunction

  assign {alu_overflow, alu_result} = alu_model(alu_in_sel, alu_out_sel, alu_num1, alu_num2);
  assign {alu_overflow3, alu_result3} = alu_model(alu_in_sel3, alu_out_sel3, alu_num1_3, alu_num2_3);

  alu_cmd_sequencer #(.WIDTH(8), .ALU_LAT(1)) dut (
    .clk(clk), .rst(rst), .on(on), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_acc(cmd_acc), .cmd_a(cmd_a), .cmd_b(cmd_b), .alu_in_sel(alu_in_sel), .alu_num1(alu_num1),
    .alu_num2(alu_num2), .alu_out_sel(alu_out_sel), .alu_result(alu_result), .alu_overflow(alu_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
  );

  alu_cmd_sequencer #(.WIDTH(8), .ALU_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .on(on), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3), .cmd_op(cmd_op3),
    .cmd_acc(cmd_acc3), .cmd_a(cmd_a3), .cmd_b(cmd_b3), .alu_in_sel(alu_in_sel3), .alu_num1(alu_num1_3),
    .alu_num2(alu_num2_3), .alu_out_sel(alu_out_sel3), .alu_result(alu_result3), .alu_overflow(alu_overflow3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_data(rsp_data3), .rsp_err(rsp_err3), .busy(busy3)
  );

  task automatic send(input logic [2:0] op, input logic accs, input logic [7:0] a, input logic [7:0] b);
    cmd_op = op;
    cmd_acc = accs;
    cmd_a = a;
    cmd_b = b;
    cmd_valid = 1;
    for (int i = 0; i < 20 && !cmd_ready; i++) @(negedge clk);
    @(negedge clk);
    cmd_valid = 0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 1;
    for (int i = 0; i < 30 && !rsp_valid; i++) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic take();
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    on = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    exp_acc = 0;
    n_checks++; if ({cmd_ready, busy, rsp_valid, rsp_err} !== 4'b1000) begin n_fail++; $display("FAIL reset_flags: got %b exp 1000", {cmd_ready, busy, rsp_valid, rsp_err}); end
    n_checks++; if (rsp_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h exp 00", rsp_data); end
    n_checks++; if ({alu_in_sel, alu_out_sel} !== {3'b001, 7'b0000100}) begin n_fail++; $display("FAIL reset_sel: got %b/%b exp 001/0000100", alu_in_sel, alu_out_sel); end
    n_checks++; if ({alu_num1, alu_num2} !== 16'h0000) begin n_fail++; $display("FAIL reset_nums: got %h/%h exp 00/00", alu_num1, alu_num2); end
    n_checks++; if ({cmd_ready3, rsp_valid3} !== 2'b10) begin n_fail++; $display("FAIL reset_dut3: got %b exp 10", {cmd_ready3, rsp_valid3}); end
  endtask

  task automatic test_add();
    int lat;
    send(3'd4, 0, 8'h05, 8'h03);
    n_checks++; if ({alu_in_sel, alu_out_sel} !== {3'b010, 7'b0000100}) begin n_fail++; $display("FAIL add_sel: got %b/%b exp 010/0000100", alu_in_sel, alu_out_sel); end
    n_checks++; if ({alu_num1, alu_num2} !== 16'h0503) begin n_fail++; $display("FAIL add_nums: got %h/%h exp 05/03", alu_num1, alu_num2); end
    n_checks++; if ({busy, cmd_ready} !== 2'b10) begin n_fail++; $display("FAIL add_busy: got %b exp 10", {busy, cmd_ready}); end
    wait_rsp(lat);
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL add_latency: got %0d exp 3", lat); end
    n_checks++; if ({rsp_err, rsp_data} !== 9'h008) begin n_fail++; $display("FAIL add_rsp: got err %b data %h exp 0/08", rsp_err, rsp_data); end
    take();
    exp_acc = 8'h08;
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL add_drop: got %b exp 0", rsp_valid); end
  endtask

  task automatic test_acc_chain();
    int lat;
    send(3'd4, 0, 8'h10, 8'h01);
    wait_rsp(lat);
    n_checks++; if (rsp_data !== 8'h11) begin n_fail++; $display("FAIL chain_first: got %h exp 11", rsp_data); end
    take();
    exp_acc = 8'h11;
    send(3'd5, 1, 8'hEE, 8'h02);
    n_checks++; if (alu_num1 !== exp_acc) begin n_fail++; $display("FAIL chain_num1: got %h exp %h", alu_num1, exp_acc); end
    n_checks++; if (alu_out_sel !== 7'b0000010) begin n_fail++; $display("FAIL chain_sel: got %b exp 0000010", alu_out_sel); end
    wait_rsp(lat);
    n_checks++; if (rsp_data !== 8'h0F) begin n_fail++; $display("FAIL chain_sub: got %h exp 0f", rsp_data); end
    take();
    exp_acc = 8'h0F;
  endtask

  task automatic test_mul_overflow();
    int lat;
    send(3'd6, 0, 8'h20, 8'h10);
    n_checks++; if (alu_out_sel !== 7'b0000001) begin n_fail++; $display("FAIL mul_sel: got %b exp 0000001", alu_out_sel); end
    wait_rsp(lat);
    n_checks++; if ({rsp_err, rsp_data} !== 9'h100) begin n_fail++; $display("FAIL mul_rsp: got err %b data %h exp 1/00", rsp_err, rsp_data); end
    take();
    send(3'd4, 1, 8'h00, 8'h01);
    n_checks++; if (alu_num1 !== exp_acc) begin n_fail++; $display("FAIL mul_acc_kept: got %h exp %h", alu_num1, exp_acc); end
    wait_rsp(lat);
    n_checks++; if ({rsp_err, rsp_data} !== 9'h010) begin n_fail++; $display("FAIL mul_next: got err %b data %h exp 0/10", rsp_err, rsp_data); end
    take();
    exp_acc = 8'h10;
  endtask

  task automatic test_backpressure_off();
    int lat;
    send(3'd3, 0, 8'h3C, 8'h0F);
    wait_rsp(lat);
    cmd_op = 3'd4;
    cmd_valid = 1;
    repeat (5) begin
      n_checks++; if ({rsp_valid, rsp_err, rsp_data, cmd_ready} !== {1'b1, 1'b0, 8'h33, 1'b0}) begin n_fail++; $display("FAIL bp_hold: got v%b e%b d%h r%b exp v1 e0 d33 r0", rsp_valid, rsp_err, rsp_data, cmd_ready); end
      @(negedge clk);
    end
    cmd_valid = 0;
    take();
    exp_acc = 8'h33;
    send(3'd1, 0, 8'h50, 8'h05);
    @(negedge clk);
    on = 0;
    wait_rsp(lat);
    n_checks++; if ({rsp_valid, rsp_data} !== {1'b1, 8'h55}) begin n_fail++; $display("FAIL off_rsp: got v%b d%h exp v1 d55", rsp_valid, rsp_data); end
    take();
    exp_acc = 8'h55;
    cmd_valid = 1;
    n_checks++; if ({cmd_ready, busy, rsp_valid} !== 3'b000) begin n_fail++; $display("FAIL off_state: got %b exp 000", {cmd_ready, busy, rsp_valid}); end
    @(negedge clk);
    n_checks++; if ({cmd_ready, busy} !== 2'b00) begin n_fail++; $display("FAIL off_hold: got %b exp 00", {cmd_ready, busy}); end
    cmd_valid = 0;
    on = 1;
    @(negedge clk);
    n_checks++; if ({cmd_ready, busy} !== 2'b10) begin n_fail++; $display("FAIL off_wake: got %b exp 10", {cmd_ready, busy}); end
  endtask

  task automatic test_reset_midop();
    int lat;
    logic seen;
    send(3'd4, 0, 8'h01, 8'h02);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    exp_acc = 0;
    n_checks++; if ({rsp_valid, busy, cmd_ready} !== 3'b001) begin n_fail++; $display("FAIL rst_flags: got %b exp 001", {rsp_valid, busy, cmd_ready}); end
    n_checks++; if ({alu_in_sel, alu_out_sel, alu_num1, alu_num2} !== {3'b001, 7'b0000100, 16'h0}) begin n_fail++; $display("FAIL rst_alu: got %b/%b/%h/%h exp 001/0000100/00/00", alu_in_sel, alu_out_sel, alu_num1, alu_num2); end
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid) seen = 1;
    end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rst_discard: got %b exp 0", seen); end
    send(3'd4, 1, 8'hAA, 8'h07);
    n_checks++; if (alu_num1 !== 8'h00) begin n_fail++; $display("FAIL rst_acc: got %h exp 00", alu_num1); end
    wait_rsp(lat);
    n_checks++; if (rsp_data !== 8'h07) begin n_fail++; $display("FAIL rst_add: got %h exp 07", rsp_data); end
    take();
    exp_acc = 8'h07;
    send(3'd7, 0, 8'h33, 8'h44);
    n_checks++; if ({alu_in_sel, alu_out_sel} !== {3'b001, 7'b0000100}) begin n_fail++; $display("FAIL clr_sel: got %b/%b exp 001/0000100", alu_in_sel, alu_out_sel); end
    wait_rsp(lat);
    n_checks++; if ({rsp_valid, rsp_err, rsp_data} !== {1'b1, 9'h000}) begin n_fail++; $display("FAIL clr_rsp: got v%b e%b d%h exp v1 e0 d00", rsp_valid, rsp_err, rsp_data); end
    take();
    exp_acc = 0;
    send(3'd4, 1, 8'h99, 8'h00);
    n_checks++; if (alu_num1 !== 8'h00) begin n_fail++; $display("FAIL clr_acc: got %h exp 00", alu_num1); end
    wait_rsp(lat);
    take();
  endtask

  task automatic test_latency3();
    int lat;
    logic stable;
    logic [25:0] snap;
    cmd_op3 = 3'd2;
    cmd_acc3 = 0;
    cmd_a3 = 8'hA5;
    cmd_b3 = 8'($urandom);
    cmd_valid3 = 1;
    for (int i = 0; i < 20 && !cmd_ready3; i++) @(negedge clk);
    @(negedge clk);
    cmd_valid3 = 0;
    n_checks++; if ({alu_in_sel3, alu_out_sel3, alu_num1_3} !== {3'b010, 7'b0010000, 8'hA5}) begin n_fail++; $display("FAIL lat3_issue: got %b/%b/%h exp 010/0010000/a5", alu_in_sel3, alu_out_sel3, alu_num1_3); end
    snap = {alu_in_sel3, alu_out_sel3, alu_num1_3, alu_num2_3};
    lat = 1;
    stable = 1;
    for (int i = 0; i < 30 && !rsp_valid3; i++) begin
      @(negedge clk);
      lat++;
      if (!rsp_valid3 && {alu_in_sel3, alu_out_sel3, alu_num1_3, alu_num2_3} !== snap) stable = 0;
    end
    n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL lat3_latency: got %0d exp 5", lat); end
    n_checks++; if (stable !== 1'b1) begin n_fail++; $display("FAIL lat3_stable: got %b exp 1", stable); end
    n_checks++; if ({rsp_err3, rsp_data3} !== 9'h05A) begin n_fail++; $display("FAIL lat3_rsp: got e%b d%h exp e0 d5a", rsp_err3, rsp_data3); end
    rsp_ready3 = 1;
    @(negedge clk);
    rsp_ready3 = 0;
    n_checks++; if ({rsp_valid3, cmd_ready3} !== 2'b01) begin n_fail++; $display("FAIL lat3_done: got %b exp 01", {rsp_valid3, cmd_ready3}); end
  endtask

  task automatic test_random();
    int lat, d;
    logic [2:0] op;
    logic accs;
    logic [7:0] a, b, ea;
    logic [8:0] er;
    for (int n = 0; n < 40; n++) begin
      op = 3'($urandom_range(0, 7));
      accs = 1'($urandom);
      a = 8'($urandom);
      b = 8'($urandom);
      ea = accs ? exp_acc : a;
      er = ref_op(op, ea, b);
      send(op, accs, a, b);
      n_checks++; if ({alu_num1, alu_num2} !== {ea, b}) begin n_fail++; $display("FAIL rand_nums[%0d]: got %h/%h exp %h/%h", n, alu_num1, alu_num2, ea, b); end
      n_checks++; if ({alu_in_sel, alu_out_sel} !== {(op == 3'd7 ? 3'b001 : 3'b010), sel_tab[op]}) begin n_fail++; $display("FAIL rand_sel[%0d]: got %b/%b op %0d", n, alu_in_sel, alu_out_sel, op); end
      wait_rsp(lat);
      n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL rand_latency[%0d]: got %0d exp 3", n, lat); end
      d = $urandom_range(0, 3);
      repeat (d) begin
        @(negedge clk);
        n_checks++; if ({rsp_valid, rsp_err, rsp_data} !== {1'b1, er}) begin n_fail++; $display("FAIL rand_hold[%0d]: got v%b e%b d%h exp v1 e%b d%h", n, rsp_valid, rsp_err, rsp_data, er[8], er[7:0]); end
      end
      n_checks++; if ({rsp_err, rsp_data} !== er) begin n_fail++; $display("FAIL rand_rsp[%0d]: op %0d got e%b d%h exp e%b d%h", n, op, rsp_err, rsp_data, er[8], er[7:0]); end
      take();
      exp_acc = op == 3'd7 ? 8'h00 : er[8] ? exp_acc : er[7:0];
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_acc_chain();
    test_mul_overflow();
    test_backpressure_off();
    test_reset_midop();
    test_latency3();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Upstream command stage for the 8-bit ALU datapath. Accepts one operation per valid/ready handshake and drives the ALU's one-hot input and output selects and its two operands. It waits the ALU's register latency, captures the result and overflow, and returns them on a valid/ready response port. It keeps a shadow accumulator so chained operations never rely on the ALU's persist feedback path.

Parameters:
WIDTH, 8, operand/result width
ALU_LAT, 1, cycles from the ISSUE cycle's clock edge until alu_result is sampled; legal range 1..15

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
on  in  1  power enable; 0 parks the FSM in OFF
cmd_valid  in  1  command present
cmd_ready  out  1  sequencer accepts command
cmd_op  in  3  0 AND, 1 OR, 2 NOT, 3 XOR, 4 ADD, 5 SUB, 6 MUL, 7 CLR
cmd_acc  in  1  1: operand A = accumulator; 0: operand A = cmd_a
cmd_a  in  WIDTH  operand A
cmd_b  in  WIDTH  operand B
alu_in_sel  out  3  one-hot {persist, load, reset}
alu_num1  out  WIDTH  ALU operand 1
alu_num2  out  WIDTH  ALU operand 2
alu_out_sel  out  7  one-hot {and, or, not, xor, add, sub, mult}, bit6 = and
alu_result  in  WIDTH  ALU output value
alu_overflow  in  1  ALU multiply overflow
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_data  out  WIDTH  captured result
rsp_err  out  1  MUL overflow on this response
busy  out  1  high in every state except IDLE and OFF

Behaviour:
- Single clock, clk. Reset is synchronous, active-high, port rst.
- Reset values:
  - State IDLE, accumulator 0, rsp_valid 0, rsp_data 0, rsp_err 0, busy 0.
  - alu_in_sel 3'b001 (reset), alu_num1 0, alu_num2 0, alu_out_sel 7'b0000100 (add).
  - cmd_ready is 1 after reset if on = 1.
- States:
  - OFF: on = 1 -> IDLE.
  - IDLE: on = 0 -> OFF; cmd_valid && cmd_ready -> ISSUE, latching op, operand A and cmd_b.
  - ISSUE: exactly 1 cycle, then -> WAIT.
  - WAIT: counts ALU_LAT cycles, samples result in the last one, then -> RESP.
  - RESP: rsp_valid && rsp_ready -> IDLE if on = 1, otherwise -> OFF.
- cmd_ready = 1 only in IDLE with on = 1. No new command is taken while a response is pending.
- Operand A is resolved at acceptance: cmd_acc ? accumulator : cmd_a. The accumulator value used is the one before any update in that cycle.
- ALU drive in ISSUE and WAIT:
  - alu_in_sel = load (3'b010); for CLR, alu_in_sel = reset (3'b001).
  - alu_num1 = latched operand A, alu_num2 = latched operand B.
  - alu_out_sel = one-hot of the latched op; CLR drives add.
  - All ALU outputs stay constant through WAIT.
- ALU drive in IDLE, OFF and RESP: outputs hold their last values. The persist code (3'b100) is never driven.
- Result capture, at the last WAIT cycle:
  - rsp_data <= alu_result; CLR forces 0.
  - rsp_err <= alu_overflow && op == MUL.
  - Accumulator <= alu_result unless rsp_err is set; CLR sets it to 0. On error the accumulator is unchanged.
- Latency, ALU_LAT = 1:
  - Command accepted at the edge ending cycle N.
  - ISSUE in cycle N+1; WAIT in cycle N+2; rsp_valid high from cycle N+3.
  - General case: rsp_valid is first high in cycle N+2+ALU_LAT.
- Response holds stable while rsp_valid && !rsp_ready. rsp_valid drops the cycle after the handshake.
- on = 0 mid-operation: the current operation completes and its response is delivered, then the FSM enters OFF.
- rst mid-operation: abort. The FSM goes to IDLE with every output at its reset value. The in-flight response is discarded and never presented.
- Arithmetic is performed by the ALU only. The sequencer does no arithmetic beyond the WAIT counter, which is 4 bits and saturates at ALU_LAT.

Test Plan:
- ADD: reset, then cmd ADD a = 8'h05, b = 8'h03, acc = 0 -> alu_in_sel 3'b010 and alu_out_sel 7'b0000100 in ISSUE; rsp_valid 3 cycles after acceptance; rsp_data 8'h08, rsp_err 0.
- Accumulator chain: ADD 8'h10 + 8'h01, then SUB with acc = 1, b = 8'h02 -> second alu_num1 = 8'h11; rsp_data 8'h0F; accumulator 8'h0F.
- MUL overflow: 8'h20 * 8'h10 with alu_overflow = 1 -> rsp_err 1; accumulator keeps its prior value; next acc-based ADD uses the old accumulator.
- Backpressure and OFF: rsp_ready held 0 for 5 cycles -> rsp_data/rsp_err stable and cmd_ready 0 throughout; on dropped during WAIT -> response still delivered, then OFF with cmd_ready 0; on = 1 -> IDLE.
- Reset mid-op: rst in the WAIT cycle -> next cycle IDLE, rsp_valid 0, accumulator 0, alu_in_sel 3'b001; a following CLR returns rsp_data 0.
- Latency parameter: ALU_LAT = 3, NOT a = 8'hA5 -> rsp_valid 5 cycles after acceptance; rsp_data 8'h5A; ALU operands constant over all 3 WAIT cycles.
